commit_trace_monitor: RTL
=========================

# commit_trace_monitor

Synthesizable commit-trace capture unit that sits beside the pipelined CPU core and records retired instructions for debug readout. Each commit stores PC, instruction word, a cycle stamp and NWATCH selected register values in an on-chip show-ahead FIFO. A run ends on a halt-PC match or a cycle budget, and the buffer is drained through a simple valid/ready-style read port. This replaces simulation-only trace dumps with hardware that also works on the board.

## Interface
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- NWATCH, 2, number of 32-bit watched register values per entry, 1..8
- CW, 16, width of cycle counter, cycle stamp and drop counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms capture (IDLE or HALTED to RUN)
- cycle_limit  in  CW  run budget in cycles; 0 = unlimited
- halt_pc  in  32  PC value that terminates the run
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  32  PC of the retiring instruction
- commit_instr  in  32  instruction word of the retiring instruction
- watch_data  in  32*NWATCH  watched register values; channel k at bits [32k+31:32k]
- rd_en  in  1  pop request
- rd_valid  out  1  FIFO not empty; rd_data is valid
- rd_data  out  CW+64+32*NWATCH  head entry {stamp, pc, instr, watch_data}, stamp at MSBs
- state  out  2  IDLE=0, RUN=1, HALTED=2
- done  out  1  high while state is HALTED
- cycle_cnt  out  CW  cycles elapsed in the current run
- drop_cnt  out  CW  commits lost to a full FIFO; saturates at all-ones

## Operation
- Reset: state IDLE, cycle_cnt 0, drop_cnt 0, FIFO empty, rd_valid 0, done 0. rd_data is don't-care while empty.
- IDLE, start: go to RUN, clear cycle_cnt, drop_cnt and FIFO pointers.
- HALTED, start: same as IDLE. Unread entries are discarded.
- RUN, start: ignored.
- RUN, every cycle: cycle_cnt increments.
- RUN, commit_valid=1:
  - Entry = {cycle_cnt (pre-increment value), commit_pc, commit_instr, watch_data}.
  - Push if not full, or if full and a pop happens in the same cycle.
  - Otherwise the entry is dropped and drop_cnt increments (saturating).
- RUN to HALTED, either condition on the same edge:
  - commit_valid and commit_pc == halt_pc. This commit is still captured or dropped as normal.
  - cycle_limit ≠ 0 and the incremented cycle_cnt == cycle_limit. A commit in that cycle is still captured.
- HALTED: no capture; cycle_cnt frozen; FIFO drainable.
- Read port works in all states. rd_en with rd_valid pops the head. rd_en while empty is ignored.
- Simultaneous push and pop while empty: pushed entry becomes visible next cycle; pop ignored.

## Timing
- Capture latency: an entry accepted at edge N appears at rd_data (rd_valid=1) after edge N if FIFO was empty.
- Show-ahead: rd_data is combinational from the head register; a pop at edge N presents the next entry after edge N.
- state, done, cycle_cnt, drop_cnt are registered outputs; they change only on clk edges or rst assertion.
- Wrap-around: pointers carry one extra bit. Full when indices are equal and wrap bits differ; empty when both are equal.
- cycle_cnt wraps modulo 2^CW when cycle_limit=0.
- rst mid-run: immediate return to reset values; no partial state survives.

## Structure
- Package trace_pkg holds:
  - state encodings IDLE/RUN/HALTED
  - entry field offsets as functions of CW and NWATCH
- Sub-module trace_fifo: parametrised (WIDTH, DEPTH) show-ahead synchronous FIFO with push/pop/full/empty.
- The top level contains the FSM, counters and entry packing.

## Test plan
- Reset then start, cycle_limit=0, halt_pc=0x130, commits at PCs 0x0,0x4,…,0x130 each cycle -> 77 entries requested. With DEPTH=128, 77 entries read in order; stamps 0..76; done=1 after 0x130 commit; drop_cnt=0.
- DEPTH=16, no reads, 20 commits -> first 16 stored; drop_cnt=4; rd_valid=1.
- FIFO full, simultaneous commit and rd_en -> pop and push both succeed; drop_cnt unchanged; count stays 16.
- cycle_limit=300, no halt match -> HALTED after 300 RUN cycles; cycle_cnt=300; later commits ignored.
- Assert rst during RUN with 5 entries buffered -> state=0, rd_valid=0, counters 0 in the same cycle. A subsequent start restarts stamps at 0.
- Start in HALTED with 3 unread entries -> FIFO empty next cycle, state=RUN, drop_cnt=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace monitor: FSM encodings and the
// bit layout of one packed trace entry.
package trace_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Entry layout, MSB to LSB: {stamp, pc, instr, watch[NWATCH-1:0]}.
  function automatic int entry_width(int cw, int nwatch);
    return cw + 64 + 32 * nwatch;
  endfunction

  function automatic int instr_lsb(int nwatch);
    return 32 * nwatch;
  endfunction

  function automatic int pc_lsb(int nwatch);
    return 32 * nwatch + 32;
  endfunction

  function automatic int stamp_lsb(int nwatch);
    return 32 * nwatch + 64;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO; the head entry is presented combinationally
// and pointers carry one wrap bit to tell full from empty.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop frees the head slot on the same edge, so a full FIFO may still accept.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit-trace capture unit: run/halt FSM, cycle and drop counters, and
// packing of each retired instruction into the trace FIFO.
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NWATCH = 2,
  parameter int CW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CW-1:0]            cycle_limit,
  input  logic [31:0]              halt_pc,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [32*NWATCH-1:0]     watch_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [CW+64+32*NWATCH-1:0] rd_data,
  output logic [1:0]               state,
  output logic                     done,
  output logic [CW-1:0]            cycle_cnt,
  output logic [CW-1:0]            drop_cnt
);

  localparam int EW = entry_width(CW, NWATCH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cycle_q, cycle_d, drop_q, drop_d, cycle_inc;
  logic [EW-1:0] entry;
  logic          run, arm, capture, drop, halt_hit, fifo_full, fifo_empty;

  assign run       = (state_q == ST_RUN);
  assign arm       = start && !run;
  assign capture   = run && commit_valid;
  assign cycle_inc = cycle_q + CW'(1);
  assign drop      = capture && fifo_full && !rd_en;
  assign halt_hit  = run && ((commit_valid && (commit_pc == halt_pc)) ||
                             ((cycle_limit != '0) && (cycle_inc == cycle_limit)));

  always_comb begin
    entry = '0;
    entry[stamp_lsb(NWATCH) +: CW] = cycle_q;
    entry[pc_lsb(NWATCH)    +: 32] = commit_pc;
    entry[instr_lsb(NWATCH) +: 32] = commit_instr;
    entry[32*NWATCH-1:0]           = watch_data;
  end

  // NOTE: every variable gets a default before the branches so this block
  // stays purely combinational and never infers a latch.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    drop_d  = drop_q;
    if (arm) begin
      state_d = ST_RUN;
      cycle_d = '0;
      drop_d  = '0;
    end else if (run) begin
      cycle_d = cycle_inc;
      if (drop && (drop_q != '1)) drop_d = drop_q + CW'(1);
      if (halt_hit) state_d = ST_HALTED;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .push  (capture),
    .pop   (rd_en),
    .wdata (entry),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid  = !fifo_empty;
  assign state     = state_q;
  assign done      = (state_q == ST_HALTED);
  assign cycle_cnt = cycle_q;
  assign drop_cnt  = drop_q;

endmodule
